ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//  Receive-only PS/2 device-to-host deserializer. Samples the keyboard's ps2_clk/ps2_data lines.
//  Delivers each validated 8-bit scan-code byte as a one-cycle strobe to the make/break decode
//  FSM (controlpath) directly downstream. Open-drain tristate is handled at top level; this block only reads the lines.
// PARAMETERS
//  FILTER_LEN   8      consecutive identical CLOCK_50 samples required before filtered ps2_clk changes
//  TIMEOUT_CYC  100000 idle CLOCK_50 cycles mid-frame (2 ms) before the frame is abandoned
// PORTS
//  CLOCK_50   in   1  50 MHz system clock, the only clock
//  resetn     in   1  asynchronous, active-low reset
//  ps2_clk    in   1  raw PS/2 clock line (asynchronous)
//  ps2_data   in   1  raw PS/2 data line (asynchronous)
//  rx_data    out  8  last good byte, LSB = first data bit; held until the next good frame
//  rx_valid   out  1  1-cycle pulse: rx_data updated this cycle
//  frame_err  out  1  1-cycle pulse: frame dropped (bad start/stop/parity, or timeout)
//  busy       out  1  high from accepted start bit until the frame ends or is dropped
// BEHAVIOUR
//  - Reset (resetn=0, async): rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, state=IDLE.
//    Synchronizers preset to 1; filtered clk=1; shift reg, bit count and timeout counter cleared.
//    Asserting reset mid-frame discards the partial frame with no pulse.
//  - Both lines pass through a 2-FF synchronizer. ps2_clk then passes the FILTER_LEN glitch filter.
//  - fall = filtered clk 1->0. Synchronized ps2_data is sampled in the same cycle as fall.
//  - FSM (on fall unless noted):
//    IDLE:   data=0 -> DATA, busy=1, cnt=0. data=1 -> remain IDLE, no error (noise).
//    DATA:   shift in LSB-first; after the 8th bit -> PARITY.
//    PARITY: capture p; -> STOP.
//    STOP:   require data=1 and odd parity (see config). Pass -> rx_data<=byte, rx_valid=1.
//            Fail -> frame_err=1. Either way -> IDLE, busy=0 in the same cycle.
//  - Latency: rx_valid is high in the cycle after the cycle in which the stop-bit fall is detected.
//  - Timeout: counter clears on every fall and counts while busy.
//    At TIMEOUT_CYC-1 -> frame_err=1, IDLE, busy=0.
//    A timeout in the same cycle as a fall: the fall wins and the counter clears.
//  - rx_valid and frame_err are never high together. No back-pressure: the consumer must
//    capture in the pulse cycle. Minimum spacing between two rx_valid pulses is 11 PS/2 bit times.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined:
//    - a frame is good only if the data ones-count plus p is odd; otherwise frame_err.
//  PS2_PARITY_CHECK_EN undefined:
//    - p is captured and ignored; only the start and stop bits are checked.
// STRUCTURE
//  ps2_pkg holds:
//    - the state encoding (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3)
//    - PS2_FRAME_BITS=11 and PS2_BREAK_CODE=8'hF0, shared with controlpath
//  One sub-module, ps2_line_filter: 2-FF sync plus the FILTER_LEN debounce; outputs the
//  filtered level and the fall strobe. Instantiated once for ps2_clk; ps2_data uses only its synchronizer.
// TESTING (bit period 60 us, clk high/low 30 us each; data changes mid-high)
//  1. Frame 0x1C (data 0,0,1,1,1,0,0,0; p=0; stop=1):
//     -> exactly one rx_valid with rx_data=8'h1C; busy low afterwards; no frame_err.
//  2. Frames 0xF0 (p=1) then 0x1C back-to-back:
//     -> two rx_valid pulses, rx_data 8'hF0 then 8'h1C; rx_data holds 8'h1C after the second.
//  3. Frame 0x00 with p=0 (bad parity):
//     -> with PS2_PARITY_CHECK_EN: frame_err pulse, rx_data unchanged.
//     -> without it: rx_valid, rx_data=8'h00.
//  4. Frame 0x1C with stop=0:
//     -> frame_err pulse, no rx_valid, busy=0.
//     A following good 0x23 frame (p=0) -> rx_valid, rx_data=8'h23.
//  5. Start bit plus 4 data bits, then clk held high 3 ms:
//     -> frame_err pulse 2 ms after the last fall.
//     A following good frame is received normally.
//  6. 100 ns low glitches on ps2_clk while idle:
//     -> no busy, no pulses.
//     resetn pulsed low mid-frame -> all outputs at reset values; no pulse on release.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: FSM state encoding, frame constants, parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int         PS2_FRAME_BITS = 11;
  localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchronizer plus FILTER_LEN-sample debounce for one PS/2 line; emits filtered level and fall strobe.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic          s1_q, s2_q, filt_q, fall_q;
  logic [CW-1:0] cnt_q;

  // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      fall_q <= 1'b0;
      if (s2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
        fall_q <= filt_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level_o = filt_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame deserializer; one-cycle rx_valid / frame_err strobes per frame.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity (default: parity ignored).
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  ps2_state_e  state_q, state_d;
  logic [7:0]  shift_q, shift_d, rx_data_q, rx_data_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d, rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        d_s1_q, d_s2_q;
  logic        clk_lvl, clk_fall, fall, par_ok, frame_ok, timeout_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk_i  (CLOCK_50),
    .rst_ni (resetn),
    .line_i (ps2_clk),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  assign fall = clk_fall & ~clk_lvl;

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = odd_parity_ok(shift_q, par_q);
`else
  logic par_unused;
  assign par_unused = par_q;
  assign par_ok     = 1'b1;
`endif

  assign frame_ok    = d_s2_q & par_ok;
  // A fall in the same cycle always beats the timeout.
  assign timeout_hit = (state_q != ST_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYC - 1)) && !fall;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      to_cnt_q    <= '0;
      d_s1_q      <= 1'b1;
      d_s2_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      to_cnt_q    <= to_cnt_d;
      d_s1_q      <= ps2_data;
      d_s2_q      <= d_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        ST_IDLE:   if (!d_s2_q) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (fall || state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
    if (timeout_hit) begin
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end
    if (fall) begin
      case (state_q)
        ST_IDLE:   if (!d_s2_q) bit_cnt_d = '0;
        ST_DATA: begin
          shift_d   = {d_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        ST_PARITY: par_d = d_s2_q;
        ST_STOP: begin
          if (frame_ok) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Randomized + directed bench for ps2_frame_receiver against a frame-level scoreboard model.
module tb_ps2_frame_receiver;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         lo;
    int         hi;
  } evt_t;

  evt_t       expq[$];
  logic [7:0] got_q[$];
  logic [7:0] model_last = 8'h00;
  int total = 0, bad = 0;
  int n_valid = 0, n_err = 0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame outcome straight from the protocol rules.
  function automatic bit exp_good(input logic [7:0] b, input logic p, input logic stop);
`ifdef PS2_PARITY_CHECK_EN
    return stop && ((($countones(b) + int'(p)) % 2) == 1);
`else
    return stop;
`endif
  endfunction

  always @(negedge CLOCK_50) begin
    if (resetn) begin : cmp
      evt_t e;
      chk("valid_err_exclusive", !(rx_valid && frame_err), {rx_valid, frame_err}, 0);
      if (rx_valid || frame_err) begin
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 1'b0, {rx_valid, frame_err}, 0);
        end else begin
          e = expq.pop_front();
          chk("pulse_kind", frame_err == e.is_err, frame_err, e.is_err);
          chk("pulse_time", cyc >= e.lo && cyc <= e.hi, cyc, e.lo);
          if (rx_valid && !e.is_err) model_last = e.data;
        end
        if (rx_valid) begin
          n_valid++;
          got_q.push_back(rx_data);
        end
        if (frame_err) n_err++;
      end
      chk("rx_data_model", rx_data === model_last, rx_data, model_last);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send(input logic [7:0] b, input logic p, input logic stop,
                      input int nbits, input bit push, input int idle);
    logic [10:0] bits;
    evt_t e;
    bits = {stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
      ps2_data = bits[i];
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      if (push && i == nbits - 1) begin
        e.data = b;
        if (nbits == 11) begin
          e.is_err = !exp_good(b, p, stop);
          e.lo = cyc + FL;
          e.hi = cyc + FL + 6;
        end else begin
          e.is_err = 1'b1;
          e.lo = cyc + TO;
          e.hi = cyc + TO + FL + 6;
        end
        expq.push_back(e);
      end
      wait_cyc(HALF);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(idle);
  endtask

  task automatic settled(input string name);
    chk({name, "_drained"}, expq.size() == 0, expq.size(), 0);
    chk({name, "_busy_low"}, busy == 1'b0, busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bv, be;
    logic [7:0] b;
    logic p, stop;

    wait_cyc(5);
    chk("reset_rx_data", rx_data == 8'h00, rx_data, 8'h00);
    chk("reset_rx_valid", rx_valid == 1'b0, rx_valid, 0);
    chk("reset_frame_err", frame_err == 1'b0, frame_err, 0);
    chk("reset_busy", busy == 1'b0, busy, 0);
    #2 resetn = 1'b1;
    wait_cyc(20);

    // 1: single good 0x1C
    bv = n_valid; be = n_err; got_q.delete();
    send(8'h1C, 1'b0, 1'b1, 11, 1'b1, 30);
    chk("t1_nvalid", n_valid - bv == 1, n_valid - bv, 1);
    chk("t1_noerr", n_err == be, n_err - be, 0);
    chk("t1_data", rx_data == 8'h1C, rx_data, 8'h1C);
    settled("t1");

    // 2: back-to-back F0, 1C
    bv = n_valid; got_q.delete();
    send(8'hF0, 1'b1, 1'b1, 11, 1'b1, 4);
    send(8'h1C, 1'b0, 1'b1, 11, 1'b1, 30);
    chk("t2_nvalid", n_valid - bv == 2, n_valid - bv, 2);
    chk("t2_first", got_q.size() > 0 && got_q[0] == 8'hF0, got_q.size() > 0 ? got_q[0] : 8'hxx, 8'hF0);
    chk("t2_second", got_q.size() > 1 && got_q[1] == 8'h1C, got_q.size() > 1 ? got_q[1] : 8'hxx, 8'h1C);
    chk("t2_hold", rx_data == 8'h1C, rx_data, 8'h1C);
    settled("t2");

    // 3: bad parity 0x00
    bv = n_valid; be = n_err;
    send(8'h00, 1'b0, 1'b1, 11, 1'b1, 30);
`ifdef PS2_PARITY_CHECK_EN
    chk("t3_err", n_err - be == 1, n_err - be, 1);
    chk("t3_hold", rx_data == 8'h1C, rx_data, 8'h1C);
`else
    chk("t3_valid", n_valid - bv == 1, n_valid - bv, 1);
    chk("t3_data", rx_data == 8'h00, rx_data, 8'h00);
`endif
    settled("t3");

    // 4: bad stop bit, then good 0x23
    bv = n_valid; be = n_err;
    send(8'h1C, 1'b0, 1'b0, 11, 1'b1, 30);
    chk("t4_err", n_err - be == 1, n_err - be, 1);
    chk("t4_novalid", n_valid == bv, n_valid - bv, 0);
    settled("t4");
    send(8'h23, 1'b0, 1'b1, 11, 1'b1, 30);
    chk("t4_data", rx_data == 8'h23, rx_data, 8'h23);

    // 5: truncated frame times out, then good 0x3C
    be = n_err;
    send(8'h5A, 1'b0, 1'b1, 5, 1'b1, TO + 40);
    chk("t5_timeout_err", n_err - be == 1, n_err - be, 1);
    settled("t5");
    send(8'h3C, 1'b1, 1'b1, 11, 1'b1, 30);
    chk("t5_data", rx_data == 8'h3C, rx_data, 8'h3C);

    // 6: short glitches while idle, then reset mid-frame
    bv = n_valid; be = n_err;
    repeat (4) begin
      ps2_clk = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b1;
      for (int k = 0; k < 20; k++) begin
        wait_cyc(1);
        chk("t6_glitch_busy", busy == 1'b0, busy, 0);
      end
    end
    chk("t6_glitch_nopulse", n_valid == bv && n_err == be, n_valid + n_err - bv - be, 0);
    send(8'hAA, 1'b0, 1'b1, 4, 1'b0, 0);
    chk("t6_busy_midframe", busy == 1'b1, busy, 1);
    @(negedge CLOCK_50);
    #2 resetn = 1'b0;
    model_last = 8'h00;
    wait_cyc(3);
    chk("t6_rst_rx_data", rx_data == 8'h00, rx_data, 8'h00);
    chk("t6_rst_pulses", rx_valid == 1'b0 && frame_err == 1'b0, {rx_valid, frame_err}, 0);
    chk("t6_rst_busy", busy == 1'b0, busy, 0);
    #2 resetn = 1'b1;
    wait_cyc(TO + 40);
    chk("t6_no_pulse_after_rst", n_valid == bv && n_err == be, n_valid + n_err - bv - be, 0);
    settled("t6");
    send(8'h45, 1'b0, 1'b1, 11, 1'b1, 30);
    chk("t6_data", rx_data == 8'h45, rx_data, 8'h45);

    // Randomized frames against the scoreboard
    for (int k = 0; k < 30; k++) begin
      b    = 8'($urandom);
      p    = ~(^b);
      if ($urandom_range(3) == 0) p = ~p;
      stop = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(9) == 0)
        send(b, p, stop, $urandom_range(1, 10), 1'b1, TO + 40);
      else
        send(b, p, stop, 11, 1'b1, $urandom_range(2, 40));
    end
    wait_cyc(50);
    settled("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
